// File: rtl/txfifo_router.sv
// txfifo_router: DEPTH-entry first-word-fall-through TX FIFO that steers each beat to one of NCH
// AXI-stream outputs by tdest. Define TXFIFO_BCAST_EN to make tdest == NCH a broadcast.
module txfifo_router #(
   parameter int DW     = 32,
   parameter int NCH    = 3,
   parameter int DEPTH  = 16,
   parameter int AF_LVL = 12,
   parameter int DESTW  = $clog2(NCH + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DW-1:0]                s_tdata,
   input  logic [DESTW-1:0]             s_tdest,
   input  logic                         s_tlast,
   input  logic                         s_tvalid,
   output logic                         s_tready,
   output logic [NCH*DW-1:0]            m_tdata,
   output logic [NCH-1:0]               m_tlast,
   output logic [NCH-1:0]               m_tvalid,
   input  logic [NCH-1:0]               m_tready,
   input  logic [NCH-1:0]               ch_en,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         s_almost_full,
   output logic [7:0]                   drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [DW-1:0]    mem_data_q [DEPTH];
   logic [DESTW-1:0] mem_dest_q [DEPTH];
   logic             mem_last_q [DEPTH];

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [7:0]       drop_q, drop_d;

   logic             full, empty, push, pop, drop;
   logic [DW-1:0]    head_data;
   logic [DESTW-1:0] head_dest;
   logic             head_last;
   logic [NCH-1:0]   sel;

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   // No pass-through: a pop in the same cycle never frees a slot for the incoming beat.
   assign s_tready = !full && !flush;
   assign push     = s_tvalid && s_tready;

   assign head_data = mem_data_q[rd_ptr_q[AW-1:0]];
   assign head_dest = mem_dest_q[rd_ptr_q[AW-1:0]];
   assign head_last = mem_last_q[rd_ptr_q[AW-1:0]];

   assign m_tdata = {NCH{head_data}};
   assign m_tlast = {NCH{head_last}};

   assign level         = LW'(wr_ptr_q - rd_ptr_q);
   assign s_almost_full = (level >= LW'(AF_LVL));
   assign drop_cnt      = drop_q;

   always_comb begin
      sel = '0;
      for (int i = 0; i < NCH; i++) begin
         sel[i] = (head_dest == DESTW'(i));
      end
   end

`ifdef TXFIFO_BCAST_EN
   logic [NCH-1:0] done_q, done_d;
   logic [NCH-1:0] bc_acc;
   logic           is_bcast;

   assign is_bcast = (head_dest == DESTW'(NCH));
`endif

   always_comb begin
      m_tvalid = '0;
      pop      = 1'b0;
      drop     = 1'b0;
`ifdef TXFIFO_BCAST_EN
      done_d   = done_q;
      bc_acc   = '0;
`endif
      if (!empty && !flush) begin
         if (|sel) begin
            // Disabled destination stalls the head; nothing behind it may overtake.
            m_tvalid = sel & ch_en;
            pop      = |(sel & ch_en & m_tready);
         end
`ifdef TXFIFO_BCAST_EN
         else if (is_bcast) begin
            m_tvalid = ch_en & ~done_q;
            bc_acc   = m_tvalid & m_tready;
            if ((ch_en != '0) && (((done_q | bc_acc) & ch_en) == ch_en)) begin
               pop    = 1'b1;
               done_d = '0;
            end else begin
               done_d = done_q | bc_acc;
            end
         end
`endif
         else begin
            pop  = 1'b1;
            drop = 1'b1;
         end
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      drop_d   = drop_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         drop_q   <= drop_d;
      end
   end

`ifdef TXFIFO_BCAST_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     done_q <= '0;
      else if (flush) done_q <= '0;
      else            done_q <= done_d;
   end
`endif

   // Storage needs no reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data_q[wr_ptr_q[AW-1:0]] <= s_tdata;
         mem_dest_q[wr_ptr_q[AW-1:0]] <= s_tdest;
         mem_last_q[wr_ptr_q[AW-1:0]] <= s_tlast;
      end
   end

endmodule

// File: tb/tb_txfifo_router.sv
// tb_txfifo_router: random and directed stimulus for txfifo_router against a queue-based
// reference model; a negedge monitor compares every cycle's outputs with the model.
module tb_txfifo_router;
   localparam int DW    = 32;
   localparam int NCH   = 3;
   localparam int DEPTH = 16;
   localparam int AF    = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DW-1:0]     s_tdata;
   logic [1:0]        s_tdest;
   logic              s_tlast;
   logic              s_tvalid;
   logic              s_tready;
   logic [NCH*DW-1:0] m_tdata;
   logic [NCH-1:0]    m_tlast;
   logic [NCH-1:0]    m_tvalid;
   logic [NCH-1:0]    m_tready;
   logic [NCH-1:0]    ch_en;
   logic              flush;
   logic [4:0]        level;
   logic              s_almost_full;
   logic [7:0]        drop_cnt;

   int n_chk = 0;
   int n_err = 0;

   txfifo_router #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .AF_LVL(AF)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_tdata(s_tdata), .s_tdest(s_tdest), .s_tlast(s_tlast),
      .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .ch_en(ch_en), .flush(flush),
      .level(level), .s_almost_full(s_almost_full), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the FIFO is a queue of accepted beats; the head follows the routing rules.
   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    dest;
      logic          last;
   } beat_t;

   beat_t          model_q[$];
   beat_t          hd;
   int             drops = 0;
   logic [NCH-1:0] done_m = '0;
   logic [NCH-1:0] exp_v, acc;
   logic           pop_m, exp_rdy;

   always @(negedge clk) begin
      if (!rst_n) begin
         model_q.delete();
         drops  = 0;
         done_m = '0;
      end else begin
         exp_rdy = (model_q.size() < DEPTH) && !flush;
         chk("level", 64'(level), 64'(model_q.size()));
         chk("almost_full", 64'(s_almost_full), 64'(model_q.size() >= AF));
         chk("s_tready", 64'(s_tready), 64'(exp_rdy));
         chk("drop_cnt", 64'(drop_cnt), 64'((drops > 255) ? 255 : drops));
         exp_v = '0;
         acc   = '0;
         pop_m = 1'b0;
         if (!flush && model_q.size() > 0) begin
            hd = model_q[0];
            if (int'(hd.dest) < NCH) begin
               if (ch_en[hd.dest]) begin
                  exp_v[hd.dest] = 1'b1;
                  pop_m = m_tready[hd.dest];
               end
            end
`ifdef TXFIFO_BCAST_EN
            else if (int'(hd.dest) == NCH) begin
               exp_v = ch_en & ~done_m;
               acc   = exp_v & m_tready;
               if (ch_en != '0 && ((done_m | acc) & ch_en) == ch_en) begin
                  pop_m  = 1'b1;
                  done_m = '0;
               end else begin
                  done_m = done_m | acc;
               end
            end
`endif
            else begin
               pop_m = 1'b1;
               drops++;
            end
         end
         chk("m_tvalid", 64'(m_tvalid), 64'(exp_v));
         for (int i = 0; i < NCH; i++) begin
            if (exp_v[i]) begin
               chk("m_tdata", 64'(m_tdata[i*DW +: DW]), 64'(hd.data));
               chk("m_tlast", 64'(m_tlast[i]), 64'(hd.last));
            end
         end
         if (flush) begin
            model_q.delete();
            done_m = '0;
         end else begin
            if (pop_m) void'(model_q.pop_front());
            if (s_tvalid && exp_rdy) model_q.push_back('{data: s_tdata, dest: s_tdest, last: s_tlast});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc();
      bit ok = 1'b0;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge clk);
         ok = s_tready;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic send(input logic [1:0] d, input logic [DW-1:0] v, input logic l);
      s_tdata  = v;
      s_tdest  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
      wait_acc();
      s_tvalid = 1'b0;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      s_tvalid = 1'b0;
      flush    = 1'b0;
      ch_en    = '1;
      m_tready = '1;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge clk);
         ok = (level == 0);
         @(posedge clk);
         #1;
      end
      if (!ok) chk("drain_timeout", 64'(level), 64'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      s_tdata  = '0;
      s_tdest  = '0;
      s_tlast  = 1'b0;
      s_tvalid = 1'b0;
      m_tready = '1;
      ch_en    = '1;
      flush    = 1'b0;
      #1;
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_af", 64'(s_almost_full), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // One beat per channel, all ready.
      send(2'd0, 32'hA0, 1'b0);
      send(2'd1, 32'hA1, 1'b0);
      send(2'd2, 32'hA2, 1'b1);
      drain();

      // Fill to full with no consumers; a 17th beat must wait.
      m_tready = '0;
      for (int i = 0; i < DEPTH; i++) send(2'(i % NCH), 32'h100 + i, 1'(i % 2));
      s_tdata  = 32'h1FF;
      s_tdest  = 2'd1;
      s_tlast  = 1'b1;
      s_tvalid = 1'b1;
      repeat (3) tick();
      m_tready = '1;
      wait_acc();
      s_tvalid = 1'b0;
      drain();

      // Head to a disabled channel stalls everything behind it.
      ch_en = 3'b101;
      send(2'd1, 32'hB1, 1'b0);
      send(2'd0, 32'hB0, 1'b0);
      send(2'd2, 32'hB2, 1'b1);
      repeat (10) tick();
      ch_en = 3'b111;
      drain();

      // Out-of-range destination (broadcast when that build option is on).
      for (int i = 0; i < 300; i++) send(2'd3, 32'hD000 + i, 1'b0);
      drain();
`ifndef TXFIFO_BCAST_EN
      chk("drop_sat", 64'(drop_cnt), 64'd255);
`endif

`ifdef TXFIFO_BCAST_EN
      // Staggered acceptance of one broadcast beat.
      m_tready = '0;
      send(2'd3, 32'hBC, 1'b1);
      m_tready = 3'b001; tick();
      m_tready = 3'b000; tick();
      m_tready = 3'b100; tick();
      m_tready = 3'b000; tick();
      m_tready = 3'b010; tick();
      m_tready = 3'b000; tick();
      drain();
`endif

      // Randomized traffic with occasional enable changes and flushes.
      for (int c = 0; c < 1500; c++) begin
         s_tvalid = 1'($urandom_range(0, 1));
         s_tdata  = $urandom;
         s_tdest  = 2'($urandom_range(0, 3));
         s_tlast  = 1'($urandom_range(0, 1));
         m_tready = 3'($urandom_range(0, 7));
         ch_en    = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
         flush    = ($urandom_range(0, 63) == 0);
         tick();
      end
      drain();

      // Flush with eight entries queued.
      m_tready = '0;
      for (int i = 0; i < 8; i++) send(2'(i % NCH), 32'hF00 + i, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      tick();

      // Asynchronous reset in the middle of a stream.
      for (int i = 0; i < 5; i++) send(2'(i % NCH), 32'hE00 + i, 1'b0);
      m_tready = '1;
      s_tvalid = 1'b1;
      s_tdest  = 2'd0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_level", 64'(level), 64'd0);
      chk("arst_tvalid", 64'(m_tvalid), 64'd0);
      chk("arst_drop", 64'(drop_cnt), 64'd0);
      chk("arst_af", 64'(s_almost_full), 64'd0);
      s_tvalid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      send(2'd2, 32'hCAFE, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
